// File: rtl/tri_solve_block.sv
// Triangular solver: forward substitution L*y = b using shared external multiplier and divider.
// Optional macro TRI_SOLVE_TRANSPOSE_EN adds the trans input for backward substitution on L^T.
module tri_solve_block #(
    parameter int N        = 6,
    parameter int W        = 36,
    parameter int MULT_LAT = 2,
    parameter int DIV_LAT  = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         start,
`ifdef TRI_SOLVE_TRANSPOSE_EN
    input  logic         trans,
`endif
    input  logic         l_we,
    input  logic [2:0]   l_row,
    input  logic [2:0]   l_col,
    input  logic [W-1:0] l_data,
    input  logic         b_we,
    input  logic [2:0]   b_addr,
    input  logic [W-1:0] b_data,
    input  logic [2:0]   y_addr,
    output logic [W-1:0] y_data,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] mult_dataa,
    output logic [W-1:0] mult_datab,
    input  logic [W-1:0] mult_result,
    output logic [W-1:0] div_dividend,
    output logic [W-1:0] div_divisor,
    input  logic [W-1:0] div_quotient
);

    localparam int CW = $clog2((MULT_LAT > DIV_LAT ? MULT_LAT : DIV_LAT) + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ROW   = 3'd1;
    localparam logic [2:0] S_MUL   = 3'd2;
    localparam logic [2:0] S_MWAIT = 3'd3;
    localparam logic [2:0] S_DIV   = 3'd4;
    localparam logic [2:0] S_DWAIT = 3'd5;
    localparam logic [2:0] S_WB    = 3'd6;
    localparam logic [2:0] S_FIN   = 3'd7;

    logic [2:0]    state_q, state_d;
    logic [2:0]    row_q, row_d;
    logic [2:0]    term_q, term_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  acc_q, acc_d;
    logic          err_q, err_d;
    logic          busy_q, done_q;
    logic [W-1:0]  y_data_q;
    logic          trans_q;
    logic          y_we;

    logic [W-1:0]  l_mem [N][N];
    logic [W-1:0]  b_mem [N];
    logic [W-1:0]  y_q   [N];

    logic [2:0]    row_i, col_i;
    logic [W-1:0]  coef, diag;
    logic          in_mul, in_div;

    // Step row_q always has row_q terms; transposed mode walks rows and columns from the bottom.
    assign row_i = trans_q ? 3'(N - 1) - row_q  : row_q;
    assign col_i = trans_q ? 3'(N - 1) - term_q : term_q;
    assign coef  = trans_q ? l_mem[col_i][row_i] : l_mem[row_i][col_i];
    assign diag  = l_mem[row_i][row_i];

    assign in_mul = (state_q == S_MUL) || (state_q == S_MWAIT);
    // The quotient is consumed in WB, so the divider operands stay up through it.
    assign in_div = (state_q == S_DIV) || (state_q == S_DWAIT) || (state_q == S_WB);

    assign mult_dataa   = in_mul ? coef        : '0;
    assign mult_datab   = in_mul ? y_q[col_i]  : '0;
    assign div_dividend = in_div ? acc_q       : '0;
    assign div_divisor  = in_div ? diag        : '0;

    assign y_data = y_data_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        state_d = state_q;
        row_d   = row_q;
        term_d  = term_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        err_d   = err_q;
        y_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ROW;
                    row_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_ROW: begin
                acc_d   = b_mem[row_i];
                term_d  = '0;
                state_d = (row_q != 3'd0) ? S_MUL : S_DIV;
            end
            S_MUL: begin
                state_d = S_MWAIT;
                cnt_d   = CW'(MULT_LAT - 1);
            end
            S_MWAIT: begin
                if (cnt_q == '0) begin
                    acc_d   = acc_q - mult_result;
                    term_d  = term_q + 3'd1;
                    state_d = ((term_q + 3'd1) < row_q) ? S_MUL : S_DIV;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DIV: begin
                if (diag == '0) err_d = 1'b1;
                if (DIV_LAT > 1) begin
                    state_d = S_DWAIT;
                    cnt_d   = CW'(DIV_LAT - 2);
                end else begin
                    state_d = S_WB;
                end
            end
            S_DWAIT: begin
                if (cnt_q == '0) state_d = S_WB;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_WB: begin
                y_we = 1'b1;
                if (row_q == 3'(N - 1)) begin
                    state_d = S_FIN;
                end else begin
                    row_d   = row_q + 3'd1;
                    state_d = S_ROW;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            term_q   <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            y_data_q <= '0;
            for (int k = 0; k < N; k++) y_q[k] <= '0;
        end else if (en) begin
            state_q  <= state_d;
            row_q    <= row_d;
            term_q   <= term_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            err_q    <= err_d;
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_d == S_FIN);
            if (y_we) y_q[row_i] <= div_quotient;
            y_data_q <= (int'(y_addr) < N) ? y_q[y_addr] : '0;
        end
    end

    // NOTE: coefficient and RHS storage is deliberately not reset so a reset keeps the loaded system.
    always_ff @(posedge clk) begin
        if (!rst && en && state_q == S_IDLE) begin
            if (l_we && int'(l_row) < N && int'(l_col) < N) l_mem[l_row][l_col] <= l_data;
            if (b_we && int'(b_addr) < N) b_mem[b_addr] <= b_data;
        end
    end

`ifdef TRI_SOLVE_TRANSPOSE_EN
    always_ff @(posedge clk) begin
        if (rst)                                     trans_q <= 1'b0;
        else if (en && state_q == S_IDLE && start)   trans_q <= trans;
    end
`else
    assign trans_q = 1'b0;
`endif

endmodule

// File: tb/tb_tri_solve_block.sv
// Self-checking bench for tri_solve_block with fixed-point multiplier/divider models and a reference solver.
module tb_tri_solve_block;

    localparam int N        = 6;
    localparam int W        = 36;
    localparam int MULT_LAT = 2;
    localparam int DIV_LAT  = 4;
    localparam int FRAC     = 18;
    localparam logic [W-1:0] ONE = W'(1) << FRAC;

    logic         clk = 1'b0;
    logic         rst, en, start;
`ifdef TRI_SOLVE_TRANSPOSE_EN
    logic         trans;
`endif
    logic         l_we, b_we;
    logic [2:0]   l_row, l_col, b_addr, y_addr;
    logic [W-1:0] l_data, b_data, y_data;
    logic         busy, done, err;
    logic [W-1:0] mult_dataa, mult_datab, mult_result;
    logic [W-1:0] div_dividend, div_divisor, div_quotient;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] lm [N][N];
    logic [W-1:0] bm [N];
    logic [W-1:0] exp_y [N];
    logic         exp_err;
    logic [W-1:0] mpipe [MULT_LAT];
    logic [W-1:0] dpipe [DIV_LAT];

    tri_solve_block #(.N(N), .W(W), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start),
`ifdef TRI_SOLVE_TRANSPOSE_EN
        .trans(trans),
`endif
        .l_we(l_we), .l_row(l_row), .l_col(l_col), .l_data(l_data),
        .b_we(b_we), .b_addr(b_addr), .b_data(b_data),
        .y_addr(y_addr), .y_data(y_data),
        .busy(busy), .done(done), .err(err),
        .mult_dataa(mult_dataa), .mult_datab(mult_datab), .mult_result(mult_result),
        .div_dividend(div_dividend), .div_divisor(div_divisor), .div_quotient(div_quotient)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] fxmul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        return p[FRAC+W-1:FRAC];
    endfunction

    // Divide by zero yields all ones, which the solver must pass through untouched.
    function automatic logic [W-1:0] fxdiv(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] n, d, q;
        if (b == '0) return '1;
        n = $signed({{W{a[W-1]}}, a}) <<< FRAC;
        d = $signed({{W{b[W-1]}}, b});
        q = n / d;
        return q[W-1:0];
    endfunction

    function automatic logic [W-1:0] fx(input int k);
        logic signed [W-1:0] s;
        s = k;
        return s <<< FRAC;
    endfunction

    function automatic logic [W-1:0] rnd_fx(input int r);
        int v;
        logic signed [W-1:0] s;
        v = int'($urandom_range(0, 2 * r * (1 << FRAC))) - r * (1 << FRAC);
        s = v;
        return s;
    endfunction

    function automatic logic [W-1:0] rnd_diag();
        int v;
        logic signed [W-1:0] s;
        v = int'($urandom_range(1 << (FRAC - 1), 4 << FRAC));
        if ($urandom_range(0, 1) == 1) v = -v;
        s = v;
        return s;
    endfunction

    // Reference: textbook substitution over the whole matrix.
    function automatic void ref_solve(input bit tr);
        logic [W-1:0] acc;
        int i;
        exp_err = 1'b0;
        for (int s = 0; s < N; s++) begin
            i   = tr ? N - 1 - s : s;
            acc = bm[i];
            for (int j = 0; j < N; j++) begin
                if (!tr && j < i) acc = acc - fxmul(lm[i][j], exp_y[j]);
                if (tr && j > i)  acc = acc - fxmul(lm[j][i], exp_y[j]);
            end
            if (lm[i][i] == '0) exp_err = 1'b1;
            exp_y[i] = fxdiv(acc, lm[i][i]);
        end
    endfunction

    // External shared units: fixed-latency pipelines advancing only on enabled cycles.
    always @(posedge clk) begin
        if (en) begin
            mpipe[0] <= fxmul(mult_dataa, mult_datab);
            for (int k = 1; k < MULT_LAT; k++) mpipe[k] <= mpipe[k-1];
            dpipe[0] <= fxdiv(div_dividend, div_divisor);
            for (int k = 1; k < DIV_LAT; k++) dpipe[k] <= dpipe[k-1];
        end
    end
    assign mult_result  = mpipe[MULT_LAT-1];
    assign div_quotient = dpipe[DIV_LAT-1];

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_l(input int r, input int c, input logic [W-1:0] v);
        l_we = 1'b1; l_row = 3'(r); l_col = 3'(c); l_data = v;
        tick();
        l_we = 1'b0;
    endtask

    task automatic load_all();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) write_l(r, c, lm[r][c]);
        for (int k = 0; k < N; k++) begin
            b_we = 1'b1; b_addr = 3'(k); b_data = bm[k];
            tick();
        end
        b_we = 1'b0;
    endtask

    task automatic set_identity();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) lm[r][c] = (r == c) ? ONE : '0;
            bm[r] = fx(r + 1);
        end
    endtask

    task automatic check_y(input string tag);
        for (int k = 0; k < N; k++) begin
            y_addr = 3'(k);
            tick();
            check($sformatf("%s_y%0d", tag, k), y_data, exp_y[k]);
        end
    endtask

    task automatic run_solve(input bit tr, input bit stall, input bit poke, input bit wr_b0,
                             input logic [W-1:0] b0_val, output int lat, output logic err_done);
        int  n;
        bit  seen;
        start = 1'b1;
`ifdef TRI_SOLVE_TRANSPOSE_EN
        trans = tr;
`endif
        if (wr_b0) begin b_we = 1'b1; b_addr = 3'd0; b_data = b0_val; end
        n = 0; seen = 1'b0; err_done = 1'b0;
        while (!seen && n < 400) begin
            tick();
            n++;
            start = 1'b0; b_we = 1'b0; l_we = 1'b0;
            if (n == 1) begin
                check("busy_after_start", W'(busy), W'(1));
                check("err_clear_on_start", W'(err), W'(0));
            end
            if (poke && n == 20) begin
                start = 1'b1;
                l_we = 1'b1; l_row = 3'd5; l_col = 3'd5; l_data = fx(2);
                b_we = 1'b1; b_addr = 3'd5; b_data = fx(7);
            end
            if (stall && n == 30) begin
                en = 1'b0;
                repeat (10) begin tick(); n++; end
                en = 1'b1;
            end
            if (done) begin seen = 1'b1; err_done = err; end
        end
        lat = n;
        tick();
        check("done_single_pulse", W'(done), W'(0));
        check("busy_low_after_done", W'(busy), W'(0));
    endtask

    initial begin
        int           lat;
        logic         e;
        bit           tr, wr;
        logic [W-1:0] b0n;

        rst = 1'b1; en = 1'b1; start = 1'b0;
        l_we = 1'b0; b_we = 1'b0; l_row = '0; l_col = '0; l_data = '0;
        b_addr = '0; b_data = '0; y_addr = '0;
`ifdef TRI_SOLVE_TRANSPOSE_EN
        trans = 1'b0;
`endif
        repeat (3) tick();
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_err", W'(err), W'(0));
        check("rst_y_data", y_data, '0);
        check("rst_mult_a", mult_dataa, '0);
        check("rst_mult_b", mult_datab, '0);
        check("rst_div_n", div_dividend, '0);
        check("rst_div_d", div_divisor, '0);
        rst = 1'b0;

        // Identity system: y equals b, 82-cycle latency.
        set_identity();
        load_all();
        for (int k = 0; k < N; k++) exp_y[k] = fx(k + 1);
        run_solve(1'b0, 1'b0, 1'b0, 1'b0, '0, lat, e);
        check("ident_latency", W'(lat), W'(82));
        check("ident_err", W'(e), W'(0));
        check_y("ident");
        check("idle_mult_a", mult_dataa, '0);
        check("idle_div_d", div_divisor, '0);

        // One off-diagonal term.
        set_identity();
        lm[1][0] = ONE; bm[0] = fx(3); bm[1] = fx(5);
        load_all();
        for (int k = 0; k < N; k++) exp_y[k] = fx(k + 1);
        exp_y[0] = fx(3); exp_y[1] = fx(2);
        run_solve(1'b0, 1'b0, 1'b0, 1'b0, '0, lat, e);
        check("l10_latency", W'(lat), W'(82));
        check_y("l10");

        // Enable dropped for 10 cycles mid-solve.
        set_identity();
        load_all();
        for (int k = 0; k < N; k++) exp_y[k] = fx(k + 1);
        run_solve(1'b0, 1'b1, 1'b0, 1'b0, '0, lat, e);
        check("stall_latency", W'(lat), W'(92));
        check_y("stall");

        // Reset at cycle 40 aborts the solve and clears y; L and b survive.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (39) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", W'(busy), W'(0));
        check("abort_done", W'(done), W'(0));
        check("abort_y_data", y_data, '0);
        for (int k = 0; k < N; k++) begin
            y_addr = 3'(k);
            tick();
            check($sformatf("abort_y%0d", k), y_data, '0);
            check($sformatf("abort_no_done%0d", k), W'(done), W'(0));
        end
        for (int k = 0; k < N; k++) exp_y[k] = fx(k + 1);
        run_solve(1'b0, 1'b0, 1'b0, 1'b0, '0, lat, e);
        check("restart_latency", W'(lat), W'(82));
        check_y("restart");

        // Zero pivot on row 3; start and writes during busy are ignored.
        set_identity();
        lm[3][3] = '0;
        load_all();
        ref_solve(1'b0);
        check("zpiv_model_y3", exp_y[3], '1);
        run_solve(1'b0, 1'b0, 1'b1, 1'b0, '0, lat, e);
        check("zpiv_latency", W'(lat), W'(82));
        check("zpiv_err_at_done", W'(e), W'(1));
        check_y("zpiv");
        repeat (5) tick();
        check("zpiv_err_sticky", W'(err), W'(1));
        lm[3][3] = ONE;
        write_l(3, 3, ONE);
        check("zpiv_err_after_write", W'(err), W'(1));

        // Random systems; some with a b[0] write in the start cycle.
        for (int it = 0; it < 6; it++) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    if (c < r)       lm[r][c] = rnd_fx(2);
                    else if (c == r) lm[r][c] = rnd_diag();
                    else             lm[r][c] = W'({$urandom(), $urandom()});
                end
                bm[r] = rnd_fx(8);
            end
            load_all();
`ifdef TRI_SOLVE_TRANSPOSE_EN
            tr = (it % 2 == 1);
`else
            tr = 1'b0;
`endif
            wr  = (it == 1 || it == 4);
            b0n = rnd_fx(8);
            if (wr) bm[0] = b0n;
            ref_solve(tr);
            run_solve(tr, 1'b0, 1'b0, wr, b0n, lat, e);
            check($sformatf("rand%0d_latency", it), W'(lat), W'(82));
            check($sformatf("rand%0d_err", it), W'(e), W'(exp_err));
            check_y($sformatf("rand%0d", it));
        end

`ifdef TRI_SOLVE_TRANSPOSE_EN
        // Backward substitution on L^T.
        set_identity();
        lm[5][4] = ONE; bm[4] = fx(5); bm[5] = fx(2);
        load_all();
        for (int k = 0; k < N; k++) exp_y[k] = fx(k + 1);
        exp_y[4] = fx(3); exp_y[5] = fx(2);
        run_solve(1'b1, 1'b0, 1'b0, 1'b0, '0, lat, e);
        check("trans_latency", W'(lat), W'(82));
        check_y("trans");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
